vram_arbiter: RTL and testbench

- Shares the single-port video SRAM between two requesters: the display scanline fetcher (paced by the display timing generator) and the host/MCU register-bus bridge.
- Display has priority during active video. Host has priority during vertical blanking. A wait counter guarantees the host a slot during active video.
- Issues at most one SRAM access per clock. Returns read data to the requester that issued the read.

---
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video SRAM between the display
// fetcher and the host bridge, with a bounded host wait in active video.
module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  vblank,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic                  disp_ack,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic                  disp_rvalid,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_ce,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] MaxWait = 8'(HOST_MAX_WAIT);

  logic                  host_win;
  logic                  disp_win;
  logic [7:0]            wait_q, wait_d;
  logic                  disp_ack_q, disp_ack_d;
  logic                  host_ack_q, host_ack_d;
  logic                  mem_ce_q, mem_ce_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd2_q, rd2_d;
  logic                  rd2_host_q, rd2_host_d;
  logic                  disp_rvalid_q, disp_rvalid_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] disp_rdata_q, disp_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    host_win = 1'b0;
    priority case (1'b1)
      vblank:
        host_win = host_req;
      (host_req && wait_q == MaxWait):
        host_win = 1'b1;
      default:
        host_win = host_req && !disp_req;
    endcase
    disp_win = disp_req && !host_win;

    disp_ack_d  = disp_win;
    host_ack_d  = host_win;
    mem_ce_d    = host_win || disp_win;
    mem_we_d    = host_win && host_wr;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (host_win) begin
      mem_addr_d = host_addr;
      if (host_wr) mem_wdata_d = host_wdata;
    end else if (disp_win) begin
      mem_addr_d = disp_addr;
    end

    // The current strobe is stage one; its tag is the host ack.
    rd2_d         = mem_ce_q && !mem_we_q;
    rd2_host_d    = host_ack_q;
    host_rvalid_d = rd2_q && rd2_host_q;
    disp_rvalid_d = rd2_q && !rd2_host_q;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
    disp_rdata_d  = disp_rvalid_d ? mem_rdata : disp_rdata_q;

    wait_d = wait_q;
    if (host_win || !host_req) begin
      wait_d = 8'd0;
    end else if (!vblank && wait_q != MaxWait) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      wait_q        <= '0;
      disp_ack_q    <= 1'b0;
      host_ack_q    <= 1'b0;
      mem_ce_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd2_q         <= 1'b0;
      rd2_host_q    <= 1'b0;
      disp_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      wait_q        <= wait_d;
      disp_ack_q    <= disp_ack_d;
      host_ack_q    <= host_ack_d;
      mem_ce_q      <= mem_ce_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd2_q         <= rd2_d;
      rd2_host_q    <= rd2_host_d;
      disp_rvalid_q <= disp_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      disp_rdata_q  <= disp_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign disp_ack    = disp_ack_q;
  assign host_ack    = host_ack_q;
  assign mem_ce      = mem_ce_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of the arbitration rules.
module tb_vram_arbiter;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblank = 1'b0;
  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic        disp_ack;
  logic [15:0] disp_rdata;
  logic        disp_rvalid;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [15:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  vram_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .HOST_MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    ._reset(rst_n),
    .vblank(vblank),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_ack(disp_ack),
    .disp_rdata(disp_rdata),
    .disp_rvalid(disp_rvalid),
    .host_req(host_req),
    .host_wr(host_wr),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_ce(mem_ce),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM: unwritten words read as addr ^ 0xA5A5
  logic [15:0] sram [int];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[int'(mem_addr)] = mem_wdata;
      else if (sram.exists(int'(mem_addr)))
        mem_rdata <= sram[int'(mem_addr)];
      else mem_rdata <= mem_addr ^ 16'hA5A5;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    bit          host;
    logic [15:0] data;
  } ret_t;

  ret_t        rq[$];
  logic [15:0] ref_mem [int];
  int          cyc = 0;
  int          wcnt = 0;
  logic        e_hack, e_dack, e_ce, e_we;
  logic        e_hrv, e_drv;
  logic [15:0] e_addr, e_wdata, e_hrd, e_drd;

  function automatic logic [15:0] rd_ref(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return a ^ 16'hA5A5;
  endfunction

  // Predicts outputs for the cycle after the coming posedge.
  task automatic model();
    bit   hw, dw;
    ret_t r;
    cyc++;
    if (!rst_n) begin
      {e_hack, e_dack, e_ce, e_we, e_hrv, e_drv} = '0;
      {e_addr, e_wdata, e_hrd, e_drd} = '0;
      wcnt = 0;
      rq.delete();
      return;
    end
    if (vblank) hw = host_req;
    else if (host_req && wcnt == MW) hw = 1'b1;
    else hw = host_req && !disp_req;
    dw = disp_req && !hw;
    e_hack = hw;
    e_dack = dw;
    e_ce = hw || dw;
    e_we = hw && host_wr;
    if (hw) begin
      e_addr = host_addr;
      if (host_wr) begin
        e_wdata = host_wdata;
        ref_mem[int'(host_addr)] = host_wdata;
      end else begin
        rq.push_back('{cyc + 2, 1'b1, rd_ref(host_addr)});
      end
    end else if (dw) begin
      e_addr = disp_addr;
      rq.push_back('{cyc + 2, 1'b0, rd_ref(disp_addr)});
    end
    if (hw || !host_req) wcnt = 0;
    else if (!vblank && wcnt < MW) wcnt++;
    e_hrv = 1'b0;
    e_drv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.host) begin
        e_hrv = 1'b1;
        e_hrd = r.data;
      end else begin
        e_drv = 1'b1;
        e_drd = r.data;
      end
    end
  endtask

  int          hv_cnt, dv_cnt, da_cnt;
  int          dv_cyc[$];
  logic [15:0] dq[$];

  task automatic step();
    model();
    @(negedge clk);
    chk("ack", {host_ack, disp_ack}, {e_hack, e_dack});
    chk("ce_we", {mem_ce, mem_we}, {e_ce, e_we});
    chk("addr", mem_addr, e_addr);
    if (e_ce && e_we) chk("wdata", mem_wdata, e_wdata);
    chk("rvalid", {host_rvalid, disp_rvalid}, {e_hrv, e_drv});
    chk("hrdata", host_rdata, e_hrd);
    chk("drdata", disp_rdata, e_drd);
    if (host_rvalid) hv_cnt++;
    if (disp_ack) da_cnt++;
    if (disp_rvalid) begin
      dv_cnt++;
      dq.push_back(disp_rdata);
      dv_cyc.push_back(cyc);
    end
  endtask

  task automatic clr_mon();
    hv_cnt = 0;
    dv_cnt = 0;
    da_cnt = 0;
    dq.delete();
    dv_cyc.delete();
  endtask

  task automatic new_host();
    host_req = 1'b1;
    host_wr = 1'($urandom_range(0, 1));
    host_addr = 16'($urandom_range(0, 31));
    host_wdata = 16'($urandom);
  endtask

  task automatic drive_rand();
    if (host_req && host_ack) begin
      if ($urandom_range(0, 1) == 1) new_host();
      else host_req = 1'b0;
    end else if (host_req) begin
      if ($urandom_range(0, 15) == 0) host_req = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      new_host();
    end
    if (disp_req && disp_ack) begin
      if ($urandom_range(0, 7) != 0) disp_addr = disp_addr + 16'd1;
      else disp_req = 1'b0;
    end else if (disp_req) begin
      if ($urandom_range(0, 31) == 0) disp_req = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      disp_req = 1'b1;
      disp_addr = 16'($urandom_range(0, 31));
    end
    if ($urandom_range(0, 23) == 0) vblank = !vblank;
    if (!rst_n) rst_n = 1'($urandom_range(0, 1));
    else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
  endtask

  int gi, hgi;

  initial begin
    // reset state
    step();
    step();
    chk("rst_out", {mem_ce, host_ack, disp_ack, mem_addr}, '0);
    rst_n = 1'b1;
    step();

    // display read, then reset before its data returns
    clr_mon();
    disp_req = 1'b1;
    disp_addr = 16'h0005;
    step();
    disp_req = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_in", {mem_ce, disp_rvalid, disp_rdata}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_rv", dv_cnt, 0);

    // single host write in active video
    clr_mon();
    host_req = 1'b1;
    host_wr = 1'b1;
    host_addr = 16'h1234;
    host_wdata = 16'hBEEF;
    step();
    chk("hw", {mem_ce, mem_we, host_ack, mem_addr, mem_wdata},
        {3'b111, 16'h1234, 16'hBEEF});
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("hw_rv", hv_cnt, 0);

    // streaming display vs. pending host read: forced host slot
    clr_mon();
    gi = 0;
    hgi = 0;
    disp_req = 1'b1;
    disp_addr = 16'h0000;
    host_req = 1'b1;
    host_wr = 1'b0;
    host_addr = 16'h0042;
    for (int i = 0; i < 24; i++) begin
      step();
      if (host_ack || disp_ack) gi++;
      if (host_ack) begin
        hgi = gi;
        host_req = 1'b0;
      end
      if (disp_ack) begin
        if (disp_addr == 16'd15) disp_req = 1'b0;
        else disp_addr = disp_addr + 16'd1;
      end
    end
    chk("fslot", hgi, 9);
    chk("fslot_d", da_cnt, 16);
    chk("fslot_rd", host_rdata, 16'h0042 ^ 16'hA5A5);

    // vblank: host owns the SRAM while requesting
    clr_mon();
    vblank = 1'b1;
    disp_req = 1'b1;
    disp_addr = 16'h0200;
    host_req = 1'b1;
    host_wr = 1'b0;
    host_addr = 16'h0010;
    for (int i = 0; i < 6; i++) begin
      step();
      if (host_ack) host_addr = host_addr + 16'd1;
    end
    chk("vb_dack", da_cnt, 0);
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (disp_ack) disp_req = 1'b0;
    end
    chk("vb_dresume", da_cnt, 1);
    vblank = 1'b0;

    // pipelined display reads
    clr_mon();
    disp_req = 1'b1;
    disp_addr = 16'h0100;
    for (int i = 0; i < 9; i++) begin
      step();
      if (disp_ack) begin
        if (disp_addr == 16'h0103) disp_req = 1'b0;
        else disp_addr = disp_addr + 16'd1;
      end
    end
    chk("pipe_n", dv_cnt, 4);
    if (dq.size() == 4) begin
      chk("pipe0", dq[0], 16'hA4A5);
      chk("pipe1", dq[1], 16'hA4A4);
      chk("pipe2", dq[2], 16'hA4A7);
      chk("pipe3", dq[3], 16'hA4A6);
      chk("pipe_span", dv_cyc[3] - dv_cyc[0], 3);
    end

    // host read then display read on the next cycle
    clr_mon();
    host_req = 1'b1;
    host_wr = 1'b0;
    host_addr = 16'h0300;
    step();
    host_req = 1'b0;
    disp_req = 1'b1;
    disp_addr = 16'h0301;
    step();
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("x_hrd", host_rdata, 16'h0300 ^ 16'hA5A5);
    chk("x_drd", disp_rdata, 16'h0301 ^ 16'hA5A5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
